asrm_ctrl: RTL
==============

Name: asrm_ctrl

Overview:
- Instruction sequencer for the ASRM core: fetches 8-bit instructions, presents each to the ALU, then commits the ALU result to the register file or the program counter.
- Owns the PC and the instruction register (IR); handles sleep and jump control flow.
- Sits between instruction memory, register file and ALU; the only block with architectural sequential state besides the register file.

Parameters:
- wordsize, 16, width of PC, register data and memory address.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- mem_req  out  1  instruction fetch request.
- mem_addr  out  wordsize  fetch address (= PC).
- mem_ack  in  1  fetch data valid this cycle.
- mem_data  in  8  fetched instruction byte.
- alu_instruction  out  8  IR contents, driven to ALU.
- alu_out  in  wordsize  ALU result.
- alu_out_reg  in  4  ALU destination register id.
- rf_we  out  1  register file write enable.
- rf_waddr  out  4  register file write address.
- rf_wdata  out  wordsize  register file write data.
- wake  in  1  ends SLEEP.
- pc  out  wordsize  current PC.
- sleeping  out  1  high while in SLEEP.
- debug_pulse  out  1  one-cycle pulse when inst_debug commits.

Behaviour:
- All state updates on rising clk. `reset` low clears immediately, mid-operation included:
  - PC=0, IR=0, state=FETCH.
  - mem_req=0, rf_we=0, sleeping=0, debug_pulse=0.
- First mem_req is asserted on the first clk edge after reset releases.
- States: FETCH, EXEC, SLEEP.
- FETCH:
  - mem_req=1 and mem_addr=PC, held stable until mem_ack.
  - On mem_ack: IR<=mem_data, PC<=PC+1 (modulo 2^wordsize, so 0xFFFF wraps to 0), mem_req<=0, go to EXEC.
  - mem_ack while mem_req=0 is ignored.
- EXEC: exactly one cycle; ALU and register file reads are combinational from IR. Commit is registered, visible the cycle after EXEC:
  - If alu_out_reg==pc_id: PC<=alu_out, rf_we=0.
  - Otherwise: rf_we=1, rf_waddr=alu_out_reg, rf_wdata=alu_out. This includes sr_id from compare ops and register 0 for ordinary ops.
  - If IR==inst_slp: go to SLEEP after the commit. Otherwise go to FETCH.
  - If IR==inst_debug: debug_pulse=1 for one cycle.
- SLEEP:
  - sleeping=1, mem_req=0, PC frozen.
  - wake sampled high goes to FETCH next cycle.
  - wake high during the EXEC of slp is ignored; only wake sampled in SLEEP counts.
- Throughput: minimum 2 cycles per instruction (FETCH with same-cycle ack, then EXEC).
- jif whose condition fails: the ALU steers the write to register 0 with the unchanged value. The controller treats it as a normal commit and does not special-case it.
- rf_we is never asserted outside the cycle following EXEC.

Optional Feature:
- ASRM_SINGLE_STEP_EN defined:
  - Adds input `step` and state HOLD.
  - After each EXEC commit (non-slp), enter HOLD instead of FETCH.
  - A one-cycle `step` high moves HOLD to FETCH. `step` outside HOLD is ignored.
  - Reset enters HOLD, not FETCH.
- Undefined: no `step` port, no HOLD, behaviour as above.

Decomposition:
- Shared header asrm.vh: pc_id, sr_id, inst_slp, inst_debug, plus new state encodings ctrl_fetch, ctrl_exec, ctrl_sleep, ctrl_hold (2-bit).
- No sub-module; the FSM, PC and IR fit in one module. Instantiating asrm_alu inside is forbidden; the ALU is a sibling at core level.

Test Plan:
- Reset release with mem_ack tied high → mem_addr 0,1,2… on successive FETCH cycles; PC increments by 1 per instruction; 2 cycles per instruction.
- Fetch "add" byte, ALU stub returns out=0x0005, reg=0 → rf_we=1, waddr=0, wdata=0x0005 for exactly one cycle.
- ALU stub returns reg=pc_id, out=0x1234 → rf_we stays 0; next mem_addr=0x1234.
- PC=0xFFFF then fetch → PC wraps to 0x0000.
- inst_slp executed → sleeping=1, mem_req=0 for 10 idle cycles; wake pulse → FETCH at PC+1 of the slp.
- reset asserted while mem_req=1 and no ack → outputs cleared immediately; after release, fetch restarts at 0x0000.

Source files
------------

// File: rtl/asrm_pkg.sv
// Shared ASRM definitions: special register ids, special opcodes, controller state encodings.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package asrm_pkg;

    // Register ids as seen on the ALU destination field.
    localparam logic [3:0] pc_id = 4'd15;   // destination that redirects the PC
    localparam logic [3:0] sr_id = 4'd14;   // status register written by compare ops

    // Opcodes the controller itself has to recognise.
    localparam logic [7:0] inst_slp   = 8'hFE;
    localparam logic [7:0] inst_debug = 8'hFF;

    // Controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        ctrl_fetch = 2'd0,
        ctrl_exec  = 2'd1,
        ctrl_sleep = 2'd2,
        ctrl_hold  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/asrm_ctrl.sv
// ASRM instruction sequencer: fetch byte into IR, expose IR to ALU, commit ALU result to RF or PC.
// Latency: 2 cycles/instruction minimum (FETCH with same-cycle ack, EXEC); commit visible the cycle after EXEC.
// Backpressure: mem_req/mem_addr held until mem_ack; SLEEP stalls until wake (HOLD until step when enabled).
//
// Ports:
//   clk, reset (async, active-low)
//   mem_req/mem_addr/mem_ack/mem_data : instruction fetch handshake, address = PC
//   alu_instruction/alu_out/alu_out_reg: IR to ALU, result and destination id back
//   rf_we/rf_waddr/rf_wdata           : registered register-file write, one cycle per commit
//   wake, sleeping                    : sleep control/status
//   pc, debug_pulse                   : current PC, one-cycle pulse when inst_debug commits
// Build option: ASRM_SINGLE_STEP_EN adds input step and the HOLD state (pause after every commit).
module asrm_ctrl
    import asrm_pkg::*;
#(
    parameter int wordsize = 16
) (
    input  logic                clk,
    input  logic                reset,
`ifdef ASRM_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic                mem_req,
    output logic [wordsize-1:0] mem_addr,
    input  logic                mem_ack,
    input  logic [7:0]          mem_data,
    output logic [7:0]          alu_instruction,
    input  logic [wordsize-1:0] alu_out,
    input  logic [3:0]          alu_out_reg,
    output logic                rf_we,
    output logic [3:0]          rf_waddr,
    output logic [wordsize-1:0] rf_wdata,
    input  logic                wake,
    output logic [wordsize-1:0] pc,
    output logic                sleeping,
    output logic                debug_pulse
);

`ifdef ASRM_SINGLE_STEP_EN
    localparam ctrl_state_t reset_state = ctrl_hold;
`else
    localparam ctrl_state_t reset_state = ctrl_fetch;
`endif

    ctrl_state_t         state, state_nxt;
    logic [wordsize-1:0] pc_q, pc_nxt;
    logic [7:0]          ir_q, ir_nxt;
    logic                mem_req_q, mem_req_nxt;
    logic                rf_we_q, rf_we_nxt;
    logic [3:0]          rf_waddr_q, rf_waddr_nxt;
    logic [wordsize-1:0] rf_wdata_q, rf_wdata_nxt;
    logic                debug_q, debug_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= reset_state;
            pc_q       <= '0;
            ir_q       <= '0;
            mem_req_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            debug_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc_q       <= pc_nxt;
            ir_q       <= ir_nxt;
            mem_req_q  <= mem_req_nxt;
            rf_we_q    <= rf_we_nxt;
            rf_waddr_q <= rf_waddr_nxt;
            rf_wdata_q <= rf_wdata_nxt;
            debug_q    <= debug_nxt;
        end
    end

    // Every transition into FETCH raises mem_req in the same edge so a
    // same-cycle ack keeps the 2-cycle instruction rate. Only the FETCH entered
    // straight out of reset spends one cycle raising the request.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_q;
        ir_nxt       = ir_q;
        mem_req_nxt  = mem_req_q;
        rf_we_nxt    = 1'b0;
        rf_waddr_nxt = rf_waddr_q;
        rf_wdata_nxt = rf_wdata_q;
        debug_nxt    = 1'b0;
        case (state)
            ctrl_fetch: begin
                if (!mem_req_q) begin
                    mem_req_nxt = 1'b1;
                end else if (mem_ack) begin
                    ir_nxt      = mem_data;
                    pc_nxt      = pc_q + wordsize'(1);
                    mem_req_nxt = 1'b0;
                    state_nxt   = ctrl_exec;
                end
            end
            ctrl_exec: begin
                // A failed jif arrives as an ordinary write to register 0.
                if (alu_out_reg == pc_id) begin
                    pc_nxt = alu_out;
                end else begin
                    rf_we_nxt    = 1'b1;
                    rf_waddr_nxt = alu_out_reg;
                    rf_wdata_nxt = alu_out;
                end
                debug_nxt = (ir_q == inst_debug);
                if (ir_q == inst_slp) begin
                    state_nxt = ctrl_sleep;
                end else begin
`ifdef ASRM_SINGLE_STEP_EN
                    state_nxt   = ctrl_hold;
`else
                    state_nxt   = ctrl_fetch;
                    mem_req_nxt = 1'b1;
`endif
                end
            end
            ctrl_sleep: begin
                if (wake) begin
                    state_nxt   = ctrl_fetch;
                    mem_req_nxt = 1'b1;
                end
            end
            ctrl_hold: begin
`ifdef ASRM_SINGLE_STEP_EN
                if (step) begin
                    state_nxt   = ctrl_fetch;
                    mem_req_nxt = 1'b1;
                end
`else
                // Unreachable without single-step; recover into FETCH.
                state_nxt   = ctrl_fetch;
                mem_req_nxt = 1'b1;
`endif
            end
        endcase
    end

    assign mem_req         = mem_req_q;
    assign mem_addr        = pc_q;
    assign pc              = pc_q;
    assign alu_instruction = ir_q;
    assign rf_we           = rf_we_q;
    assign rf_waddr        = rf_waddr_q;
    assign rf_wdata        = rf_wdata_q;
    assign sleeping        = (state == ctrl_sleep);
    assign debug_pulse     = debug_q;

endmodule
